mem_fetch_sequencer: RTL

- Parametrised successor to the single-address sphere-data memory controller.
- On `start`, issues a run of `num_items` reads from `base_addr`, advancing by STRIDE each read, against the sphere memory.
- Keeps up to MAX_OUTSTANDING reads in flight and buffers the returned words in a credit-managed FIFO.
- Presents those words to the collision pipeline on a valid/ready stream, with busy/done/end_of_memory status.

---
 rtl/mem_fetch_sequencer_pkg.sv | 22 ++
 rtl/mem_fetch_sequencer_fifo.sv | 61 ++++++
 rtl/mem_fetch_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_fetch_sequencer_pkg.sv
// rtl/mem_fetch_sequencer_pkg.sv - sphere memory map, sequencer state encoding and sizing helper
package mem_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // Number of valid sphere records in the memory; last legal address is MEM_WORDS_DEFAULT-1.
  localparam int MEM_WORDS_DEFAULT = 5;

  // Width of one sphere record word.
  localparam int SPHERE_DATA_W = 32;

  // Bits needed to hold a count in the closed range 0..n.
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_fetch_sequencer_fifo.sv
// rtl/mem_fetch_sequencer_fifo.sv - fetch_fifo: small power-of-two FIFO with occupancy count
module fetch_fifo
  import mem_fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_bits(DEPTH)-1:0] count,
  output logic [W-1:0]               head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care whenever the slot is not counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must never let a word arrive with no room for it.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/mem_fetch_sequencer.sv
// rtl/mem_fetch_sequencer.sv - strided multi-read fetcher with outstanding cap and credit-managed return FIFO
module mem_fetch_sequencer
  import mem_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = SPHERE_DATA_W,
  parameter int MEM_WORDS       = MEM_WORDS_DEFAULT,
  parameter int STRIDE          = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_items,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              end_of_memory,
  output logic              protocol_err
);

  localparam int FCW = cnt_bits(FIFO_DEPTH);
  localparam int OW  = cnt_bits(MAX_OUTSTANDING);
  localparam int SW  = ((FCW > OW) ? FCW : OW) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W:0]   STRIDE_X  = (ADDR_W + 1)'(STRIDE);

  seq_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_wrapped;
  logic [CNT_W-1:0]  remaining;
  logic [OW-1:0]     outstanding;
  logic              eom_q;
  logic              perr_q;

  logic [FCW-1:0]    fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  logic [SW-1:0]     occupied;
  logic              has_credit;
  logic              addr_ok;
  logic              issue_en;
  logic              grant;
  logic              ret_ok;
  logic              pop;
  logic [ADDR_W:0]   addr_sum;

  // Every slot is reserved either by a word already buffered or by a read still in flight.
  assign occupied   = SW'(fifo_count) + SW'(outstanding);
  assign has_credit = (occupied < SW'(FIFO_DEPTH)) && !fifo_full;

  // A carry out of the address adder means the run walked off the top of the address space.
  assign addr_sum = {1'b0, addr_q} + STRIDE_X;
  assign addr_ok  = !addr_wrapped && (addr_q <= LAST_ADDR);

  assign issue_en = (state == S_ISSUE) && (remaining != '0) && has_credit &&
                    (outstanding < OW'(MAX_OUTSTANDING)) && addr_ok;
  assign grant    = issue_en && mem_rd_gnt;
  assign ret_ok   = mem_rd_valid && (outstanding != '0);
  assign pop      = !fifo_empty && out_ready;

  assign mem_rd_en     = issue_en;
  assign mem_addr      = issue_en ? addr_q : '0;
  assign out_valid     = !fifo_empty;
  assign out_data      = fifo_empty ? '0 : fifo_head;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign end_of_memory = eom_q;
  assign protocol_err  = perr_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_ok),
    .push_data (mem_rd_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  // Run FSM together with the address accumulator, outstanding-read tracking and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      addr_wrapped <= 1'b0;
      remaining    <= '0;
      outstanding  <= '0;
      eom_q        <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      case ({grant, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      // A return with nothing in flight is dropped and flagged rather than counted.
      if (mem_rd_valid && (outstanding == '0)) perr_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            eom_q <= 1'b0;
            if (num_items == '0) begin
              state <= S_DONE;
            end else begin
              addr_q       <= base_addr;
              addr_wrapped <= 1'b0;
              remaining    <= num_items;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (grant) begin
            addr_q    <= addr_sum[ADDR_W-1:0];
            remaining <= remaining - 1'b1;
            if (addr_sum[ADDR_W]) addr_wrapped <= 1'b1;
          end
          if ((remaining != '0) && !addr_ok) begin
            eom_q <= 1'b1;
            state <= S_DRAIN;
          end else if ((remaining == '0) || (grant && (remaining == CNT_W'(1)))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((outstanding == '0) && fifo_empty) state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
